// File: rtl/i2c_master_nbyte.sv
// I2C master for codec programming: START, address byte, 0..MAX_BYTES data bytes
// (write or read) with per-byte ACK handling and early abort on slave NACK, then STOP.
//
// state | meaning
// IDLE  | bus released, waiting for GO
// START | one slot generating the start condition
// BIT   | eight data slots of the current byte, MSB first
// ACK   | acknowledge slot after each byte
// STOP  | one slot generating the stop condition
module i2c_master_nbyte #(
   parameter int CLK_DIV   = 32,
   parameter int MAX_BYTES = 4,
   parameter int NB_W      = $clog2(MAX_BYTES + 1)
) (
   input  logic                   CLOCK,
   input  logic                   RESET,
   input  logic                   GO,
   input  logic                   RD,
   input  logic [6:0]             DEV_ADDR,
   input  logic [NB_W-1:0]        NBYTES,
   input  logic [8*MAX_BYTES-1:0] TX_DATA,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   NACK,
   output logic [8*MAX_BYTES-1:0] RX_DATA,
   output logic                   I2C_SCLK,
   inout  wire                    I2C_SDAT
);

   localparam int              TW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [TW-1:0]   TICK_LAST = TW'(CLK_DIV - 1);
   localparam logic [NB_W-1:0] NB_MAX    = NB_W'(MAX_BYTES);

   typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;

   state_t                 state, state_nxt;
   logic [TW-1:0]          tick;
   logic [1:0]             quarter;
   logic [2:0]             bit_cnt;
   logic [NB_W-1:0]        byte_idx;
   logic [NB_W-1:0]        nbytes_q;
   logic                   rd_q;
   logic [8*MAX_BYTES-1:0] tx_q;
   logic [7:0]             tx_shift;
   logic [7:0]             rx_shift;
   logic                   scl;
   logic                   sda_low;
   logic                   sda_in;
   logic                   quarter_end;
   logic                   sample_end;
   logic                   slot_end;
   logic                   reading_byte;
   logic                   last_byte;

   assign sda_in       = I2C_SDAT;
   assign I2C_SDAT     = sda_low ? 1'b0 : 1'bz;
   assign I2C_SCLK     = scl;
   assign BUSY         = (state != IDLE);
   assign quarter_end  = (state != IDLE) && (tick == TICK_LAST);
   assign sample_end   = quarter_end && (quarter == 2'd2);
   assign slot_end     = quarter_end && (quarter == 2'd3);
   // byte 0 is always the address, which the master drives even in a read
   assign reading_byte = rd_q && (byte_idx != '0);
   assign last_byte    = (byte_idx == nbytes_q);

   always_comb begin
      state_nxt = state;
      scl       = 1'b1;
      sda_low   = 1'b0;
      case (state)
         IDLE: begin
            if (GO) state_nxt = START;
         end
         START: begin
            scl     = (quarter != 2'd3);
            sda_low = (quarter != 2'd0);
            if (slot_end) state_nxt = BIT;
         end
         BIT: begin
            scl     = quarter[1] ^ quarter[0];
            sda_low = !reading_byte && !tx_shift[7];
            if (slot_end && bit_cnt == 3'd7) state_nxt = ACK;
         end
         ACK: begin
            scl     = quarter[1] ^ quarter[0];
            sda_low = reading_byte && !last_byte;
            if (slot_end) state_nxt = (NACK || last_byte) ? STOP : BIT;
         end
         STOP: begin
            scl     = (quarter != 2'd0);
            sda_low = !quarter[1];
            if (slot_end) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state    <= IDLE;
         tick     <= '0;
         quarter  <= '0;
         bit_cnt  <= '0;
         byte_idx <= '0;
         nbytes_q <= '0;
         rd_q     <= 1'b0;
         tx_q     <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         DONE     <= 1'b0;
         NACK     <= 1'b0;
         RX_DATA  <= '0;
      end else begin
         state <= state_nxt;
         DONE  <= (state == STOP) && slot_end;
         if (state == IDLE) begin
            tick    <= '0;
            quarter <= '0;
            if (GO) begin
               rd_q     <= RD;
               nbytes_q <= (NBYTES > NB_MAX) ? NB_MAX : NBYTES;
               tx_q     <= TX_DATA;
               tx_shift <= {DEV_ADDR, RD};
               byte_idx <= '0;
               bit_cnt  <= '0;
               NACK     <= 1'b0;
            end
         end else begin
            tick <= quarter_end ? '0 : tick + 1'b1;
            if (quarter_end) quarter <= quarter + 2'd1;
            if (sample_end && state == BIT) rx_shift <= {rx_shift[6:0], sda_in};
            // NACK is sticky until the next GO and steers ACK -> STOP
            if (sample_end && state == ACK && !reading_byte && sda_in) NACK <= 1'b1;
            if (slot_end && state == BIT) begin
               bit_cnt  <= bit_cnt + 3'd1;
               tx_shift <= {tx_shift[6:0], 1'b0};
               if (bit_cnt == 3'd7 && reading_byte) begin
                  for (int k = 0; k < MAX_BYTES; k++) begin
                     if (byte_idx == NB_W'(k + 1)) RX_DATA[8*k +: 8] <= rx_shift;
                  end
               end
            end
            if (slot_end && state == ACK) begin
               byte_idx <= byte_idx + 1'b1;
               tx_shift <= tx_q[7:0];
               tx_q     <= tx_q >> 8;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_master_nbyte.sv
// Bench for i2c_master_nbyte: bus-level slave model, transaction-level reference model
// and a scoreboard checked whenever DONE pulses.
module tb_i2c_master_nbyte;

   localparam int CLK_DIV   = 4;
   localparam int MAX_BYTES = 4;
   localparam int NB_W      = 3;

   logic                   clock = 1'b0;
   logic                   reset = 1'b1;
   logic                   go = 1'b0;
   logic                   rd = 1'b0;
   logic [6:0]             dev_addr = '0;
   logic [NB_W-1:0]        nbytes = '0;
   logic [8*MAX_BYTES-1:0] tx_data = '0;
   logic                   busy;
   logic                   done;
   logic                   nack;
   logic [8*MAX_BYTES-1:0] rx_data;
   logic                   scl_line;
   wire                    sda_line;
   logic                   slave_low = 1'b0;

   pullup (sda_line);
   assign sda_line = slave_low ? 1'b0 : 1'bz;

   i2c_master_nbyte #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .NB_W(NB_W)) dut (
      .CLOCK(clock), .RESET(reset), .GO(go), .RD(rd), .DEV_ADDR(dev_addr),
      .NBYTES(nbytes), .TX_DATA(tx_data), .BUSY(busy), .DONE(done), .NACK(nack),
      .RX_DATA(rx_data), .I2C_SCLK(scl_line), .I2C_SDAT(sda_line)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          done_at;
      logic        nack;
      logic [31:0] rx;
      logic [39:0] bus;
      int          nbus;
      logic [4:0]  acks;
      int          pulses;
   } exp_t;

   exp_t sb_q[$];
   int   done_cnt = 0;

   // slave configuration, set by the driver before each transaction
   int          s_nack_at = -1;
   logic [7:0]  s_rdata [4];

   // what the slave/bus monitor observed in the current transaction
   logic [39:0] bus_bytes;
   int          nbus;
   logic [4:0]  acks;
   int          pulses;
   int          stops;

   // bus-level slave: decodes START/STOP, captures bytes on SCL rise, drives on SCL fall
   initial begin
      bit         s_active = 0, s_seen_rise = 0, s_rd = 0, s_quiet = 0;
      bit         prev_scl = 1, prev_sda = 1;
      int         s_bit = 0, s_byte = 0;
      logic [7:0] s_shift = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            s_active = 0; s_seen_rise = 0; slave_low = 1'b0; prev_scl = 1; prev_sda = 1;
         end else begin
            if (scl_line && prev_scl && prev_sda && !sda_line) begin
               s_active = 1; s_seen_rise = 0; s_bit = 0; s_byte = 0; s_shift = '0;
               s_quiet = 0; s_rd = 0; slave_low = 1'b0;
               bus_bytes = '0; nbus = 0; acks = '0; pulses = 0; stops = 0;
            end else if (scl_line && prev_scl && !prev_sda && sda_line) begin
               if (s_active) stops++;
               s_active = 0; slave_low = 1'b0;
            end else if (s_active && scl_line && !prev_scl) begin
               s_seen_rise = 1;
               if (s_bit < 8) s_shift = {s_shift[6:0], sda_line};
               else if (s_byte < 5) acks[s_byte] = sda_line;
            end else if (s_active && !scl_line && prev_scl && s_seen_rise) begin
               s_seen_rise = 0;
               pulses++;
               if (s_bit < 8) begin
                  s_bit++;
                  if (s_bit == 8) begin
                     if (s_byte < 5) bus_bytes[8*s_byte +: 8] = s_shift;
                     nbus++;
                     if (s_byte == 0) s_rd = s_shift[0];
                     if (s_byte == 0 || !s_rd) slave_low = (s_nack_at != s_byte);
                     else slave_low = 1'b0;
                  end else if (s_rd && s_byte >= 1 && s_byte <= 4 && !s_quiet) begin
                     slave_low = !s_rdata[s_byte-1][7-s_bit];
                  end
               end else begin
                  if (s_byte < 5 && acks[s_byte]) s_quiet = 1;
                  s_bit = 0;
                  s_byte++;
                  slave_low = 1'b0;
                  if (s_rd && !s_quiet && s_byte <= 4) slave_low = !s_rdata[s_byte-1][7];
               end
            end
            prev_scl = scl_line;
            prev_sda = sda_line;
         end
      end
   end

   // scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
               check("unexpected_done", 1'b1, 1'b0);
            end else begin
               e = sb_q.pop_front();
               check("done_time", 64'(cyc), 64'(e.done_at));
               check("nack", nack, e.nack);
               check("rx_data", rx_data, e.rx);
               check("bus_bytes", bus_bytes, e.bus);
               check("byte_count", 64'(nbus), 64'(e.nbus));
               check("ack_bits", acks, e.acks);
               check("scl_pulses", 64'(pulses), 64'(e.pulses));
               check("stop_seen", 64'(stops), 64'd1);
               check("busy_low", busy, 1'b0);
            end
         end
      end
   end

   logic [31:0] model_rx = '0;

   task automatic run_txn(input logic r, input logic [6:0] a, input int nb_in,
                          input logic [31:0] tx, input int nack_at,
                          input logic [31:0] rdat, input bit ghost);
      exp_t e;
      int   nb, last, start_cnt;
      bit   ab;
      s_nack_at = nack_at;
      for (int k = 0; k < 4; k++) s_rdata[k] = rdat[8*k +: 8];
      nb   = (nb_in > MAX_BYTES) ? MAX_BYTES : nb_in;
      ab   = (nack_at >= 0) && (nack_at <= nb) && (nack_at == 0 || !r);
      last = ab ? nack_at : nb;
      e.bus = '0;
      e.bus[7:0] = {a, r};
      for (int k = 1; k <= last; k++) e.bus[8*k +: 8] = r ? rdat[8*(k-1) +: 8] : tx[8*(k-1) +: 8];
      e.acks = '0;
      for (int b = 0; b <= last; b++) begin
         if (b == 0 || !r) e.acks[b] = (b == nack_at);
         else e.acks[b] = (b == nb);
      end
      if (r) for (int k = 0; k < last; k++) model_rx[8*k +: 8] = rdat[8*k +: 8];
      e.rx     = model_rx;
      e.nack   = ab;
      e.nbus   = last + 1;
      e.pulses = 9 * (last + 1);

      @(negedge clock);
      go = 1'b1; rd = r; dev_addr = a; nbytes = NB_W'(nb_in); tx_data = tx;
      @(posedge clock);
      #1;
      e.done_at = cyc + 4 * CLK_DIV * (2 + 9 * (last + 1));
      sb_q.push_back(e);
      start_cnt = done_cnt;
      @(negedge clock);
      go = 1'b0; rd = 1'($urandom); dev_addr = 7'($urandom);
      nbytes = NB_W'($urandom); tx_data = $urandom;
      if (ghost) begin
         repeat (98) @(negedge clock);
         go = 1'b1; rd = ~r; dev_addr = ~a; nbytes = 3'd1; tx_data = ~tx;
         @(negedge clock);
         go = 1'b0;
      end
      for (int i = 0; i < 3000 && done_cnt == start_cnt; i++) @(negedge clock);
      check("done_seen", 64'(done_cnt != start_cnt), 64'd1);
      if (done_cnt == start_cnt) sb_q.delete();
      @(negedge clock);
      check("done_one_cycle", done, 1'b0);
   endtask

   initial begin
      int nb, na;
      logic r;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_nack", nack, 1'b0);
      check("rst_rx", rx_data, 32'h0);
      check("rst_scl", scl_line, 1'b1);
      check("rst_sda", sda_line, 1'b1);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      run_txn(1'b0, 7'h1A, 2, 32'h0000_3412, -1, 32'h0, 1'b0);
      run_txn(1'b1, 7'h11, 4, 32'h0, -1, 32'hC3B2_A190, 1'b0);
      run_txn(1'b1, 7'h50, 3, 32'h0, -1, 32'h00FF_5AA5, 1'b0);
      run_txn(1'b0, 7'h3C, 4, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
      run_txn(1'b0, 7'h3C, 0, 32'h0, -1, 32'h0, 1'b0);
      run_txn(1'b0, 7'h22, 7, 32'h8877_6655, -1, 32'h0, 1'b0);
      run_txn(1'b0, 7'h22, 4, 32'h8877_6655, 3, 32'h0, 1'b0);
      run_txn(1'b0, 7'h1A, 2, 32'h0000_3412, -1, 32'h0, 1'b1);

      for (int t = 0; t < 20; t++) begin
         r  = 1'($urandom);
         nb = $urandom_range(0, 7);
         if (r && nb == 0) nb = 1;
         na = -1;
         if ($urandom_range(0, 3) == 0)
            na = r ? 0 : $urandom_range(0, (nb > MAX_BYTES) ? MAX_BYTES : nb);
         run_txn(r, 7'($urandom), nb, $urandom, na, $urandom, 1'b0);
      end

      // reset in the middle of the address byte
      @(negedge clock);
      go = 1'b1; rd = 1'b0; dev_addr = 7'h55; nbytes = 3'd4; tx_data = 32'h0;
      @(negedge clock);
      go = 1'b0;
      repeat (40) @(negedge clock);
      check("mid_busy_before_reset", busy, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_scl", scl_line, 1'b1);
      check("mid_rst_sda", sda_line, 1'b1);
      check("mid_rst_nack", nack, 1'b0);
      check("mid_rst_rx", rx_data, 32'h0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      model_rx = '0;
      repeat (2) @(negedge clock);
      run_txn(1'b1, 7'h0F, 2, 32'h0, -1, 32'h1234_9A7E, 1'b0);

      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
